// File: rtl/axi_line_fill_pkg.sv
// Shared types and AXI4 encodings for the cache line-fill engine.
// The line-size defaults are shared with the cache and its property module.
package axi_line_fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        BEAT,
        GAP,
        DONE
    } fill_state_t;

    localparam int LINE_BYTES_DEF = 128;
    localparam int WORD_BYTES_DEF = 4;
    localparam int BEATS          = LINE_BYTES_DEF / WORD_BYTES_DEF;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // ARSIZE is log2 of the bytes per beat.
    function automatic logic [2:0] axi_size_enc(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi_line_fill_if.sv
// Cache fill side plus AXI4 read-address/read-data channels of the refill engine.
// The master modport is the engine view; slave is the cache/interconnect view.
interface axi_line_fill_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              miss;
    logic [ADDR_W-1:0] cpu_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_data_valid;
    logic              mem_last;
    logic              fill_err;

    logic [ID_W-1:0]   m_arid;
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready;

    logic [ID_W-1:0]   m_rid;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;

    modport master (
        input  miss, cpu_addr,
        output mem_addr, mem_data_in, mem_data_valid, mem_last, fill_err,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready
    );

    modport slave (
        output miss, cpu_addr,
        input  mem_addr, mem_data_in, mem_data_valid, mem_last, fill_err,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready
    );

endinterface

// File: rtl/axi_line_fill.sv
// Cache refill engine: one AXI4 INCR burst per miss, returned to the cache
// one word per pulse with a one-cycle bubble between words.
module axi_line_fill
    import axi_line_fill_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    parameter int ID_W       = 4,
    parameter int AR_ID      = 0
) (
    input  logic             clk,
    input  logic             reset,
    axi_line_fill_if.master  bus
);

    localparam int WORD_BYTES = DATA_W / 8;
    localparam int LINE_BEATS = LINE_BYTES / WORD_BYTES;
    localparam int BEAT_W     = $clog2(LINE_BEATS);
    localparam int OFF_W      = $clog2(LINE_BYTES);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);
    localparam logic [ID_W-1:0]   ARID_C    = ID_W'(AR_ID);

    fill_state_t       r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_err;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_miss_q;

    logic              w_miss_rise;
    logic              w_r_hs;
    logic              w_beat_bad;
    logic [ADDR_W-1:0] w_line_base;
    logic              w_unused;

    assign w_miss_rise = bus.miss && !r_miss_q;
    assign w_r_hs      = bus.m_rvalid && r_rready;
    assign w_line_base = {bus.cpu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign w_unused    = &{1'b0, bus.cpu_addr[OFF_W-1:0]};

    // RLAST must appear exactly on the final beat; anywhere else is an error.
    assign w_beat_bad = (bus.m_rresp != AXI_RESP_OKAY)
                     || (bus.m_rid != ARID_C)
                     || (bus.m_rlast != (r_beat == LAST_BEAT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_base     <= '0;
            r_mem_addr <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_miss_q   <= 1'b0;
        end else begin
            r_miss_q <= bus.miss;
            case (r_state)
                IDLE: begin
                    if (w_miss_rise) begin
                        r_base     <= w_line_base;
                        r_mem_addr <= w_line_base;
                        r_beat     <= '0;
                        r_arvalid  <= 1'b1;
                        r_state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (r_arvalid && bus.m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= BEAT;
                    end
                end
                BEAT: begin
                    if (w_r_hs) begin
                        r_data   <= bus.m_rdata;
                        r_valid  <= 1'b1;
                        r_last   <= (r_beat == LAST_BEAT);
                        r_err    <= r_err || w_beat_bad;
                        r_beat   <= r_beat + BEAT_W'(1);
                        r_rready <= 1'b0;
                        r_state  <= GAP;
                    end
                end
                GAP: begin
                    // Beat counter wraps to zero once the whole line is in.
                    r_valid    <= 1'b0;
                    r_last     <= 1'b0;
                    r_mem_addr <= r_mem_addr + WORD_STEP;
                    if (r_beat == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_rready <= 1'b1;
                        r_state  <= BEAT;
                    end
                end
                DONE: begin
                    if (!bus.miss) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_data_in    = r_data;
    assign bus.mem_data_valid = r_valid;
    assign bus.mem_last       = r_last;
    assign bus.fill_err       = r_err;

    assign bus.m_arid    = ARID_C;
    assign bus.m_araddr  = r_base;
    assign bus.m_arlen   = 8'(LINE_BEATS - 1);
    assign bus.m_arsize  = axi_size_enc(WORD_BYTES);
    assign bus.m_arburst = AXI_BURST_INCR;
    assign bus.m_arvalid = r_arvalid;
    assign bus.m_rready  = r_rready;

endmodule

// File: tb/tb_axi_line_fill.sv
// Directed bench for axi_line_fill: an AXI read responder plus one task per scenario.
module tb_axi_line_fill;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_line_fill_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus();

    axi_line_fill #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(128), .ID_W(ID_W), .AR_ID(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc_cnt  = 0;
    int t_miss   = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Responder controls (written by the main sequence only)
    int          r_gen       = 0;
    bit          r_en        = 1'b0;
    int          r_err_beat  = -1;
    int          r_last_beat = 31;
    logic [31:0] r_seed      = 32'h0;
    int          rbeat       = 0;

    // Keeps RVALID high while beats remain; beat k carries seed + k*0x01010101.
    initial begin : responder
        int seen_gen;
        bit hs;
        seen_gen = 0;
        hs = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        bus.m_rresp  = 2'b00;
        bus.m_rlast  = 1'b0;
        bus.m_rid    = '0;
        forever begin
            @(negedge clk);
            if (seen_gen != r_gen) begin
                seen_gen = r_gen;
                rbeat = 0;
            end else if (hs) begin
                rbeat++;
            end
            bus.m_rvalid = r_en && (rbeat < 32);
            bus.m_rdata  = r_seed + 32'(rbeat) * 32'h0101_0101;
            bus.m_rresp  = (rbeat == r_err_beat) ? 2'b10 : 2'b00;
            bus.m_rlast  = (rbeat == r_last_beat);
            hs = bus.m_rvalid && bus.m_rready && !reset;
        end
    end

    logic [15:0] c_addr [32];
    logic [31:0] c_data [32];
    logic        c_last [32];
    logic        c_fe   [32];
    int c_n, c_consec, c_rr_consec, c_first_cyc, c_extra;

    task automatic collect();
        bit prev_v, prev_rr;
        prev_v = 1'b0; prev_rr = 1'b0;
        c_n = 0; c_consec = 0; c_rr_consec = 0; c_first_cyc = -1; c_extra = 0;
        for (int k = 0; k < 300 && c_n < 32; k++) begin
            @(negedge clk);
            if (bus.mem_data_valid) begin
                if (prev_v) c_consec++;
                if (c_n == 0) c_first_cyc = cyc_cnt;
                c_addr[c_n] = bus.mem_addr;
                c_data[c_n] = bus.mem_data_in;
                c_last[c_n] = bus.mem_last;
                c_fe[c_n]   = bus.fill_err;
                c_n++;
            end
            if (bus.m_rready && prev_rr) c_rr_consec++;
            prev_v  = bus.mem_data_valid;
            prev_rr = bus.m_rready;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.mem_data_valid) c_extra++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.miss = 1'b0;
        bus.m_arready = 1'b0;
        r_en = 1'b0;
        r_gen++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic begin_burst(input logic [15:0] addr, input logic [31:0] seed);
        r_seed = seed;
        r_gen++;
        r_en = 1'b1;
        repeat (2) @(negedge clk);
        bus.miss = 1'b1;
        bus.cpu_addr = addr;
        t_miss = cyc_cnt;
    endtask

    task automatic end_burst();
        @(negedge clk);
        bus.miss = 1'b0;
        r_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({bus.m_arvalid, bus.m_rready, bus.mem_data_valid, bus.mem_last, bus.fill_err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b required 00000",
                     {bus.m_arvalid, bus.m_rready, bus.mem_data_valid, bus.mem_last, bus.fill_err});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.mem_addr, bus.m_araddr, bus.mem_data_in} !== 64'h0)
            $display("FAIL reset_data: mem_addr=%h araddr=%h data=%h required 0",
                     bus.mem_addr, bus.m_araddr, bus.mem_data_in);
        else pass_cnt++;
        chk_cnt++;
        if ({bus.m_arlen, bus.m_arsize, bus.m_arburst, bus.m_arid} !== {8'd31, 3'd2, 2'b01, 4'd0})
            $display("FAIL reset_ar_const: len=%0d size=%0d burst=%0d id=%0d required 31/2/1/0",
                     bus.m_arlen, bus.m_arsize, bus.m_arburst, bus.m_arid);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bad_a, bad_d, bad_l;
        r_err_beat = -1; r_last_beat = 31;
        bus.m_arready = 1'b1;
        begin_burst(16'h1234, 32'hA500_0000);
        @(negedge clk);
        chk_cnt++;
        if ({bus.m_arvalid, bus.m_araddr, bus.m_arlen, bus.m_arsize, bus.m_arburst}
            !== {1'b1, 16'h1200, 8'd31, 3'd2, 2'b01})
            $display("FAIL basic_ar: valid=%b addr=%h len=%0d size=%0d burst=%0d required 1/1200/31/2/1",
                     bus.m_arvalid, bus.m_araddr, bus.m_arlen, bus.m_arsize, bus.m_arburst);
        else pass_cnt++;
        chk_cnt++;
        if (bus.mem_addr !== 16'h1200)
            $display("FAIL basic_memaddr_init: got %h required 1200", bus.mem_addr);
        else pass_cnt++;
        collect();
        bad_a = 0; bad_d = 0; bad_l = 0;
        for (int i = 0; i < c_n; i++) begin
            if (c_addr[i] !== 16'(16'h1200 + 4 * i)) bad_a++;
            if (c_data[i] !== 32'hA500_0000 + 32'(i) * 32'h0101_0101) bad_d++;
            if (c_last[i] !== (i == 31)) bad_l++;
        end
        chk_cnt++;
        if (c_n !== 32) $display("FAIL basic_count: got %0d words required 32", c_n);
        else pass_cnt++;
        chk_cnt++;
        if (bad_a !== 0) $display("FAIL basic_addr: %0d wrong addresses required 0", bad_a);
        else pass_cnt++;
        chk_cnt++;
        if (bad_d !== 0) $display("FAIL basic_data: %0d wrong words required 0", bad_d);
        else pass_cnt++;
        chk_cnt++;
        if (bad_l !== 0) $display("FAIL basic_last: %0d misplaced mem_last required 0", bad_l);
        else pass_cnt++;
        chk_cnt++;
        if ({c_consec, c_rr_consec} !== {32'd0, 32'd0})
            $display("FAIL basic_bubble: consec_valid=%0d consec_rready=%0d required 0/0",
                     c_consec, c_rr_consec);
        else pass_cnt++;
        chk_cnt++;
        if ((c_first_cyc - t_miss >= 2) !== 1'b1)
            $display("FAIL basic_latency: first valid %0d cycles after miss required >=2",
                     c_first_cyc - t_miss);
        else pass_cnt++;
        chk_cnt++;
        if ({c_extra[0], bus.fill_err} !== 2'b00 || c_extra !== 0)
            $display("FAIL basic_tail: extra=%0d fill_err=%b required 0/0", c_extra, bus.fill_err);
        else pass_cnt++;
        end_burst();
        chk_cnt++;
        if ({bus.m_arvalid, bus.m_rready, bus.mem_data_valid} !== 3'b000)
            $display("FAIL basic_idle: got %b required 000",
                     {bus.m_arvalid, bus.m_rready, bus.mem_data_valid});
        else pass_cnt++;
    endtask

    task automatic test_ar_stall();
        int bad_a;
        r_err_beat = -1; r_last_beat = 31;
        bus.m_arready = 1'b0;
        begin_burst(16'h4321, 32'h1100_0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_cnt++;
            if ({bus.m_arvalid, bus.m_araddr, bus.mem_data_valid, bus.m_rready}
                !== {1'b1, 16'h4300, 1'b0, 1'b0})
                $display("FAIL stall_ar cyc%0d: valid=%b addr=%h dv=%b rready=%b required 1/4300/0/0",
                         k, bus.m_arvalid, bus.m_araddr, bus.mem_data_valid, bus.m_rready);
            else pass_cnt++;
        end
        bus.m_arready = 1'b1;
        collect();
        bad_a = 0;
        for (int i = 0; i < c_n; i++)
            if (c_addr[i] !== 16'(16'h4300 + 4 * i) || c_last[i] !== (i == 31)) bad_a++;
        chk_cnt++;
        if (c_n !== 32 || bad_a !== 0)
            $display("FAIL stall_burst: words=%0d bad=%0d required 32/0", c_n, bad_a);
        else pass_cnt++;
        chk_cnt++;
        if ((c_first_cyc - t_miss >= 7) !== 1'b1)
            $display("FAIL stall_latency: first valid %0d cycles after miss required >=7",
                     c_first_cyc - t_miss);
        else pass_cnt++;
        end_burst();
    endtask

    task automatic test_bad_resp();
        int bad_fe, bad_d;
        r_err_beat = 7; r_last_beat = 31;
        bus.m_arready = 1'b1;
        begin_burst(16'h20F0, 32'h3300_0000);
        collect();
        bad_fe = 0; bad_d = 0;
        for (int i = 0; i < c_n; i++) begin
            if (c_fe[i] !== (i >= 7)) bad_fe++;
            if (c_data[i] !== 32'h3300_0000 + 32'(i) * 32'h0101_0101 || c_last[i] !== (i == 31)) bad_d++;
        end
        chk_cnt++;
        if (c_n !== 32 || bad_d !== 0)
            $display("FAIL resp_words: words=%0d bad=%0d required 32/0", c_n, bad_d);
        else pass_cnt++;
        chk_cnt++;
        if (bad_fe !== 0) $display("FAIL resp_fill_err: %0d wrong samples required 0", bad_fe);
        else pass_cnt++;
        end_burst();
        chk_cnt++;
        if (bus.fill_err !== 1'b1) $display("FAIL resp_sticky: got %b required 1", bus.fill_err);
        else pass_cnt++;
        r_err_beat = -1;
    endtask

    task automatic test_rlast_early();
        int bad_fe, last_cnt;
        r_err_beat = -1; r_last_beat = 30;
        bus.m_arready = 1'b1;
        begin_burst(16'h0A00, 32'h7700_0000);
        collect();
        bad_fe = 0; last_cnt = 0;
        for (int i = 0; i < c_n; i++) begin
            if (c_fe[i] !== (i >= 30)) bad_fe++;
            if (c_last[i] === 1'b1) last_cnt++;
        end
        chk_cnt++;
        if (c_n !== 32 || last_cnt !== 1 || c_last[31] !== 1'b1)
            $display("FAIL rlast_last: words=%0d lasts=%0d last31=%b required 32/1/1",
                     c_n, last_cnt, c_last[31]);
        else pass_cnt++;
        chk_cnt++;
        if (bad_fe !== 0) $display("FAIL rlast_fill_err: %0d wrong samples required 0", bad_fe);
        else pass_cnt++;
        end_burst();
        r_last_beat = 31;
    endtask

    task automatic test_reset_mid();
        int n, bad_a;
        r_err_beat = -1; r_last_beat = 31;
        bus.m_arready = 1'b1;
        begin_burst(16'h5555, 32'h5500_0000);
        n = 0;
        for (int k = 0; k < 200 && n < 12; k++) begin
            @(negedge clk);
            if (bus.mem_data_valid) n++;
        end
        chk_cnt++;
        if (n !== 12) $display("FAIL rstmid_progress: got %0d words required 12", n);
        else pass_cnt++;
        reset = 1'b1;
        bus.miss = 1'b0;
        r_en = 1'b0;
        r_gen++;
        @(negedge clk);
        chk_cnt++;
        if ({bus.m_arvalid, bus.m_rready, bus.mem_data_valid, bus.mem_last, bus.fill_err} !== 5'b0
            || {bus.mem_addr, bus.m_araddr, bus.mem_data_in} !== 64'h0)
            $display("FAIL rstmid_outputs: ctrl=%b mem_addr=%h araddr=%h data=%h required 0",
                     {bus.m_arvalid, bus.m_rready, bus.mem_data_valid, bus.mem_last, bus.fill_err},
                     bus.mem_addr, bus.m_araddr, bus.mem_data_in);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        begin_burst(16'h8000, 32'h0C00_0000);
        @(negedge clk);
        chk_cnt++;
        if ({bus.m_arvalid, bus.m_araddr} !== {1'b1, 16'h8000})
            $display("FAIL rstmid_ar: valid=%b addr=%h required 1/8000", bus.m_arvalid, bus.m_araddr);
        else pass_cnt++;
        collect();
        bad_a = 0;
        for (int i = 0; i < c_n; i++)
            if (c_addr[i] !== 16'(16'h8000 + 4 * i) || c_last[i] !== (i == 31)
                || c_data[i] !== 32'h0C00_0000 + 32'(i) * 32'h0101_0101) bad_a++;
        chk_cnt++;
        if (c_n !== 32 || bad_a !== 0 || bus.fill_err !== 1'b0)
            $display("FAIL rstmid_burst: words=%0d bad=%0d fill_err=%b required 32/0/0",
                     c_n, bad_a, bus.fill_err);
        else pass_cnt++;
        end_burst();
    endtask

    initial begin
        bus.miss      = 1'b0;
        bus.cpu_addr  = '0;
        bus.m_arready = 1'b0;
        test_reset();
        test_basic();
        test_ar_stall();
        test_bad_resp();
        do_reset();
        test_rlast_early();
        do_reset();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
